// File: rtl/auth_req_arbiter.sv
// auth_req_arbiter: round-robin PD/DEBUG authentication request arbiter driving one shared engine.
// Optional engine watchdog is compiled in with AUTH_ARB_TIMEOUT_EN.
module auth_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           pending_auth_request_PD,
    input  logic [7:0]           pending_auth_request_DEBUG,
    input  logic                 PD_ready,
    input  logic                 DEBUG_ready,
    input  logic                 eng_ack,
    input  logic                 eng_done,
    input  logic                 eng_err,
    output logic                 eng_req,
    output logic                 eng_src,
    output logic [1:0]           eng_type,
    output logic [1:0]           eng_slot,
    output logic                 pending_auth_request_PD_erase,
    output logic                 pending_auth_request_DEBUG_erase,
    output logic [1:0]           erase_idx,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 timeout_err
);
    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_DONE, ERASE} state_t;
    state_t state;
    logic last_src, pd_elig, dbg_elig, pick_dbg, finish;
    logic [7:0] sel_vec, cur_vec;
    logic [1:0] sel_slot, sel_type, cur_entry;

    function automatic logic [1:0] first_slot(input logic [7:0] v);
        return v[1:0] != 2'b00 ? 2'd0 : v[3:2] != 2'b00 ? 2'd1 : v[5:4] != 2'b00 ? 2'd2 : 2'd3;
    endfunction

    assign pd_elig   = PD_ready && |pending_auth_request_PD;
    assign dbg_elig  = DEBUG_ready && |pending_auth_request_DEBUG;
    // last_src resets to DEBUG, so a tie goes to PD first
    assign pick_dbg  = dbg_elig && (!pd_elig || !last_src);
    assign sel_vec   = pick_dbg ? pending_auth_request_DEBUG : pending_auth_request_PD;
    assign sel_slot  = first_slot(sel_vec);
    assign sel_type  = sel_vec[{sel_slot, 1'b0} +: 2];
    assign cur_vec   = eng_src ? pending_auth_request_DEBUG : pending_auth_request_PD;
    assign cur_entry = cur_vec[{eng_slot, 1'b0} +: 2];
    assign finish    = eng_done && (state == WAIT_DONE || (state == ISSUE && eng_ack));
    assign busy      = state != IDLE;

`ifdef AUTH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
`else
    // watchdog compiled out; constant 0 for any legal limit
    assign timeout_err = TIMEOUT_CYCLES < 1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                            <= IDLE;
            last_src                         <= 1'b1;
            eng_req                          <= 1'b0;
            eng_src                          <= 1'b0;
            eng_type                         <= 2'b00;
            eng_slot                         <= 2'b00;
            pending_auth_request_PD_erase    <= 1'b0;
            pending_auth_request_DEBUG_erase <= 1'b0;
            erase_idx                        <= 2'b00;
            err_cnt                          <= '0;
`ifdef AUTH_ARB_TIMEOUT_EN
            timer                            <= '0;
            timeout_err                      <= 1'b0;
`endif
        end else begin
            pending_auth_request_PD_erase    <= 1'b0;
            pending_auth_request_DEBUG_erase <= 1'b0;
`ifdef AUTH_ARB_TIMEOUT_EN
            timeout_err                      <= 1'b0;
`endif
            case (state)
                IDLE: if (pd_elig || dbg_elig) state <= SELECT;
                SELECT: begin
                    if (pd_elig || dbg_elig) begin
                        eng_src  <= pick_dbg;
                        eng_slot <= sel_slot;
                        eng_type <= sel_type;
                        last_src <= pick_dbg;
                        eng_req  <= 1'b1;
`ifdef AUTH_ARB_TIMEOUT_EN
                        timer    <= '0;
`endif
                    end
                    state <= (pd_elig || dbg_elig) ? ISSUE : IDLE;
                end
                ISSUE, WAIT_DONE: begin
`ifdef AUTH_ARB_TIMEOUT_EN
                    timer <= timer + TW'(1);
                    if (timeout_err) begin
                        state                            <= ERASE;
                        pending_auth_request_PD_erase    <= !eng_src;
                        pending_auth_request_DEBUG_erase <= eng_src;
                        erase_idx                        <= eng_slot;
                    end else if (!finish && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        eng_req     <= 1'b0;
                        if (!(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
                    end else
`endif
                    if (finish) begin
                        eng_req                          <= 1'b0;
                        state                            <= ERASE;
                        pending_auth_request_PD_erase    <= !eng_src;
                        pending_auth_request_DEBUG_erase <= eng_src;
                        erase_idx                        <= eng_slot;
                        if (eng_err && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
                    end else if (state == ISSUE && eng_ack) begin
                        eng_req <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (state == ISSUE && cur_entry == 2'b00) begin
                        eng_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ERASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
